// File: rtl/cpu_run_ctrl.sv
// Run controller: gates the core clock-enable with a divider, run/halt/step
// control, an optional PC breakpoint (CPU_RUN_CTRL_BP_EN) and a retired-instruction counter.
module cpu_run_ctrl #(
   parameter int DIV_W   = 5,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 32,
   parameter bit AUTORUN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] clkDivide,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             cnt_clr,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } state_t;

   localparam state_t RESET_STATE = state_t'(AUTORUN ? 2'd1 : 2'd0);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             tick;
   logic             bp_match;
   logic             en_int;

   // A lowered clkDivide below the running count fires at once instead of wrapping.
   assign tick      = (div_cnt_q >= clkDivide);
   assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

`ifdef CPU_RUN_CTRL_BP_EN
   logic bp_skip_q, bp_skip_d;

   assign bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;

   // Skip lets the breakpointed instruction retire once after a resume.
   always_comb begin
      bp_skip_d = bp_skip_q;
      if (state_d == ST_HALT)
         bp_skip_d = 1'b0;
      else if (state_q == ST_BREAK && (state_d == ST_RUN || state_d == ST_STEP))
         bp_skip_d = 1'b1;
      else if (en_int)
         bp_skip_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         bp_skip_q <= 1'b0;
      else
         bp_skip_q <= bp_skip_d;
   end

   assign bp_hit = !rst && (state_q == ST_BREAK);
`else
   logic unused_bp;

   assign unused_bp = ^{bp_en, bp_addr};
   assign bp_match  = 1'b0;
   assign bp_hit    = 1'b0;
`endif

   assign en_int = tick && (((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HALT: begin
            if (halt_req)      state_d = ST_HALT;
            else if (step_req) state_d = ST_STEP;
            else if (run_req)  state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req)              state_d = ST_HALT;
            else if (tick && bp_match) state_d = ST_BREAK;
         end
         ST_STEP: begin
            if (halt_req || tick) state_d = ST_HALT;
         end
         ST_BREAK: begin
            if (halt_req)      state_d = ST_HALT;
            else if (step_req) state_d = ST_STEP;
            else if (run_req)  state_d = ST_RUN;
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // Clear wins over a coincident increment; the count sticks at all-ones.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (cnt_clr)
         cycle_cnt_d = '0;
      else if (en_int && !(&cycle_cnt_q))
         cycle_cnt_d = cycle_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RESET_STATE;
         div_cnt_q   <= '0;
         cycle_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cpu_en    = en_int && !rst;
   assign halted    = rst ? (AUTORUN == 1'b0)
                          : ((state_q == ST_HALT) || (state_q == ST_BREAK));
   assign state     = state_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: vector table, directed corner sequences and random
// stimulus against a rule-level reference model; follows CPU_RUN_CTRL_BP_EN.
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_BP_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;
   localparam longint CNT_MAX = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, run_req, halt_req, step_req, cnt_clr, bp_en;
   logic [4:0]  clkDivide;
   logic [31:0] bp_addr, pc;
   logic        cpu_en, halted, bp_hit;
   logic [1:0]  state;
   logic [31:0] cycle_cnt;

   // second instance: tiny counter and AUTORUN=0
   logic        s_rst, s_run, s_clr;
   logic        s_zero1;
   logic [4:0]  s_div;
   logic [31:0] s_zero32;
   logic        s_en, s_halted, s_hit;
   logic [1:0]  s_state;
   logic [2:0]  s_cnt;

   always #5 clk = ~clk;

   cpu_run_ctrl dut (
      .clk(clk), .rst(rst), .clkDivide(clkDivide), .run_req(run_req),
      .halt_req(halt_req), .step_req(step_req), .cnt_clr(cnt_clr),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
      .halted(halted), .bp_hit(bp_hit), .state(state), .cycle_cnt(cycle_cnt)
   );

   cpu_run_ctrl #(.CNT_W(3), .AUTORUN(1'b0)) dut_s (
      .clk(clk), .rst(s_rst), .clkDivide(s_div), .run_req(s_run),
      .halt_req(s_zero1), .step_req(s_zero1), .cnt_clr(s_clr),
      .bp_en(s_zero1), .bp_addr(s_zero32), .pc(s_zero32), .cpu_en(s_en),
      .halted(s_halted), .bp_hit(s_hit), .state(s_state), .cycle_cnt(s_cnt)
   );

   typedef struct {
      bit rst, run, halt, step, clr;
      bit en, hlt;
      int st;
      int cnt;
   } vec_t;

   vec_t tab[$];
   int   n_vec = 0, n_bad = 0;

   // reference model
   int     m_mode;
   int     m_div;
   bit     m_skip;
   longint m_cnt;
   bit     core_emul = 0;
   logic [31:0] pc_mask = 32'hFFFF_FFFC;
   bit     en_seen;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_tick();
      return m_div >= int'(clkDivide);
   endfunction

   function automatic bit m_at_bp();
      return BP && bp_en && (pc == bp_addr) && !m_skip;
   endfunction

   function automatic bit m_en();
      if (rst) return 0;
      if (!m_tick()) return 0;
      if (m_mode == M_STEP) return 1;
      return (m_mode == M_RUN) && !m_at_bp();
   endfunction

   function automatic void model_update();
      int req, nxt;
      bit en;
      if (rst) begin
         m_mode = M_RUN; m_div = 0; m_skip = 0; m_cnt = 0;
         return;
      end
      en = m_en();
      // highest-priority request this cycle: 3 halt, 2 step, 1 run, 0 none
      req = halt_req ? 3 : step_req ? 2 : run_req ? 1 : 0;
      nxt = m_mode;
      if (req == 3) nxt = M_HALT;
      else if (m_mode == M_HALT || m_mode == M_BRK) begin
         if (req == 2) nxt = M_STEP;
         else if (req == 1) nxt = M_RUN;
      end else if (m_mode == M_STEP) begin
         if (m_tick()) nxt = M_HALT;
      end else if (m_tick() && m_at_bp()) nxt = M_BRK;

      if (cnt_clr) m_cnt = 0;
      else if (en && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;

      if (nxt == M_HALT) m_skip = 0;
      else if (m_mode == M_BRK && nxt != M_BRK) m_skip = 1;
      else if (en) m_skip = 0;

      m_div  = m_tick() ? 0 : (m_div + 1) % 32;
      m_mode = nxt;
   endfunction

   task automatic step_cycle(input bit use_tab, input vec_t v);
      bit hlt_exp;
      #3;
      hlt_exp = rst ? 1'b0 : (m_mode == M_HALT || m_mode == M_BRK);
      chk("cpu_en", cpu_en, m_en());
      chk("halted", halted, hlt_exp);
      chk("bp_hit", bp_hit, !rst && m_mode == M_BRK);
      chk("state", state, m_mode);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      if (use_tab) begin
         chk("tab_en", cpu_en, v.en);
         chk("tab_halted", halted, v.hlt);
         chk("tab_state", state, v.st);
         chk("tab_cnt", cycle_cnt, v.cnt);
      end
      en_seen = cpu_en;
      @(posedge clk);
      model_update();
      #1;
      if (core_emul && en_seen) pc = (pc + 32'd4) & pc_mask;
   endtask

   task automatic cyc();
      vec_t z;
      z = '{default: 0};
      step_cycle(1'b0, z);
   endtask

   task automatic idle_inputs();
      rst = 0; run_req = 0; halt_req = 0; step_req = 0; cnt_clr = 0;
   endtask

   function automatic void add(bit r, bit ru, bit h, bit s, bit c, bit e, bit hl, int st, int cn);
      vec_t v;
      v.rst = r; v.run = ru; v.halt = h; v.step = s; v.clr = c;
      v.en = e; v.hlt = hl; v.st = st; v.cnt = cn;
      tab.push_back(v);
   endfunction

   initial begin
      int pulses;
      longint base;
      vec_t z;
      z = '{default: 0};

      rst = 1; run_req = 0; halt_req = 0; step_req = 0; cnt_clr = 0;
      bp_en = 0; bp_addr = 32'h10; pc = 0; clkDivide = 0;
      s_rst = 1; s_run = 0; s_clr = 0; s_zero1 = 0; s_div = 0; s_zero32 = 0;
      @(posedge clk);
      model_update();
      #1;

      // reset / run / priority / clear vectors at clkDivide=0
      for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, M_RUN, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 1, 0, M_RUN, i);
      add(0, 1, 1, 1, 0, 1, 0, M_RUN, 10);
      add(0, 0, 0, 0, 0, 0, 1, M_HALT, 11);
      add(0, 0, 0, 0, 0, 0, 1, M_HALT, 11);
      add(0, 1, 0, 0, 0, 0, 1, M_HALT, 11);
      add(0, 0, 0, 0, 1, 1, 0, M_RUN, 11);
      add(0, 0, 0, 0, 0, 1, 0, M_RUN, 0);
      add(0, 0, 0, 0, 0, 1, 0, M_RUN, 1);
      foreach (tab[i]) begin
         rst = tab[i].rst; run_req = tab[i].run; halt_req = tab[i].halt;
         step_req = tab[i].step; cnt_clr = tab[i].clr;
         step_cycle(1'b1, tab[i]);
      end

      // divider period 4, then shrink the period below the running count
      idle_inputs(); rst = 1; clkDivide = 3; cyc(); rst = 0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin cyc(); pulses += int'(en_seen); end
      chk("div3_pulses", pulses, 2);
      rst = 1; clkDivide = 7; cyc(); rst = 0;
      for (int i = 0; i < 5; i++) begin cyc(); chk("div7_quiet", en_seen, 0); end
      clkDivide = 1;
      for (int i = 0; i < 5; i++) begin cyc(); chk("div_shrink", en_seen, (i % 2 == 0)); end

      // single step from HALT
      halt_req = 1; cyc(); halt_req = 0; clkDivide = 2;
      for (int i = 0; i < 3; i++) cyc();
      base = m_cnt;
      pulses = 0;
      step_req = 1; cyc(); pulses += int'(en_seen); step_req = 0;
      for (int i = 0; i < 4; i++) begin cyc(); pulses += int'(en_seen); end
      chk("step_pulses", pulses, 1);
      chk("step_state", state, M_HALT);
      chk("step_cnt", cycle_cnt, base + 1);

      // breakpoint at 0x10 with the core advancing pc by 4
      rst = 1; clkDivide = 0; cyc(); rst = 0;
      pc = 0; bp_en = 1; bp_addr = 32'h10; core_emul = 1; pc_mask = 32'hFFFF_FFFC;
      for (int i = 0; i < 7; i++) cyc();
      chk("bp_state", state, BP ? M_BRK : M_RUN);
      chk("bp_hit_flag", bp_hit, BP);
      chk("bp_pc", pc, BP ? 32'h10 : 32'h1C);
      run_req = 1; cyc(); run_req = 0;
      cyc();
      chk("bp_resume_en", en_seen, 1);
      cyc(); cyc();
      chk("bp_past", pc > 32'h14, 1);
      chk("bp_run_state", state, M_RUN);

      // random stimulus against the model
      pc_mask = 32'h1C;
      for (int i = 0; i < 1500; i++) begin
         rst      = ($urandom_range(0, 59) == 0);
         run_req  = ($urandom_range(0, 7) == 0);
         halt_req = ($urandom_range(0, 13) == 0);
         step_req = ($urandom_range(0, 9) == 0);
         cnt_clr  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) clkDivide = 5'($urandom_range(0, 4));
         if ($urandom_range(0, 39) == 0) bp_en = ~bp_en;
         if ($urandom_range(0, 49) == 0) bp_addr = ($urandom_range(0, 1) != 0) ? 32'h8 : 32'h10;
         cyc();
      end

      // AUTORUN=0 reset state and counter saturation on the narrow instance
      idle_inputs(); core_emul = 0;
      cyc(); cyc();
      chk("s_rst_halted", s_halted, 1);
      chk("s_rst_en", s_en, 0);
      chk("s_rst_state", s_state, M_HALT);
      chk("s_rst_cnt", s_cnt, 0);
      s_rst = 0; cyc(); cyc();
      chk("s_idle_state", s_state, M_HALT);
      chk("s_idle_en", s_en, 0);
      chk("s_idle_hit", s_hit, 0);
      s_run = 1; cyc(); s_run = 0;
      chk("s_run_state", s_state, M_RUN);
      for (int i = 0; i < 10; i++) cyc();
      chk("s_sat_cnt", s_cnt, 7);
      chk("s_sat_en", s_en, 1);
      s_clr = 1; cyc(); s_clr = 0;
      chk("s_clr_cnt", s_cnt, 0);
      cyc();
      chk("s_after_clr", s_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
